// File: rtl/fft_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fft_pkg: shared defaults and state encoding for the FFT sample feeder.
// Rev 1.0
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int c_DATAW     = 32;
  localparam int c_DEPTH     = 4;
  localparam int c_FRAME_LEN = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } feed_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_feed_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fft_feed_fifo: small circular FIFO with occupancy count and synchronous clear.
// Rev 1.0
// -----------------------------------------------------------------------------
module fft_feed_fifo #(
  parameter int DATAW = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATAW-1:0]         din,
  output logic [DATAW-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_FULL_LVL = CW'(DEPTH);

  logic [DATAW-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == c_FULL_LVL);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // A full FIFO still takes a write when the head leaves on the same edge.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !clr) r_mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/fft_sample_feeder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fft_sample_feeder: buffers pipeline samples and frames them for the FFT core.
// Optional FFT_FEEDER_STATS_EN adds a 16-bit frame_count output.  Rev 1.0
// -----------------------------------------------------------------------------
module fft_sample_feeder
  import fft_pkg::*;
#(
  parameter int DATAW     = c_DATAW,
  parameter int DEPTH     = c_DEPTH,
  parameter int FRAME_LEN = c_FRAME_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fft_wr_en_in,
  input  logic [DATAW-1:0] ex_data_in,
  input  logic             abort,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             stall_out,
  output logic             frame_done,
  output logic             overflow
`ifdef FFT_FEEDER_STATS_EN
  ,
  output logic [15:0]      frame_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] c_STALL_LVL = CW'(DEPTH - 1);
  localparam logic [IW-1:0] c_LAST_IDX  = IW'(FRAME_LEN - 1);

  feed_state_t      r_state, w_state_next;
  logic [IW-1:0]    r_idx, w_idx_next;
  logic             r_frame_done, w_frame_done_next;
  logic             r_overflow;

  logic [DATAW-1:0] w_dout;
  logic [CW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push_acc;
  logic             w_drop;

  fft_feed_fifo #(
    .DATAW (DATAW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (abort),
    .push  (fft_wr_en_in),
    .pop   (w_pop),
    .din   (ex_data_in),
    .dout  (w_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign out_valid  = ~w_empty;
  assign out_data   = out_valid ? w_dout : '0;
  assign out_last   = out_valid & (r_idx == c_LAST_IDX);
  // One slot of headroom absorbs the write already in flight when stall rises.
  assign stall_out  = (w_count >= c_STALL_LVL);
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

  assign w_pop      = out_valid & out_ready;
  assign w_push_acc = fft_wr_en_in & (~w_full | w_pop);
  assign w_drop     = fft_wr_en_in & w_full & ~w_pop & ~abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_frame_done <= w_frame_done_next;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_idx_next        = r_idx;
    w_frame_done_next = 1'b0;
    if (abort) begin
      w_state_next = IDLE;
      w_idx_next   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_idx_next = '0;
          if (w_push_acc) w_state_next = STREAM;
        end
        STREAM: begin
          if (w_pop) begin
            w_idx_next        = r_idx + 1'b1;
            w_frame_done_next = out_last;
            if (out_last && (w_count == CW'(1)) && !w_push_acc) w_state_next = IDLE;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_idx_next   = '0;
        end
      endcase
    end
  end

`ifdef FFT_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= '0;
    end else if (w_pop && out_last && !abort) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_sample_feeder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_fft_sample_feeder: vector table, directed corner sequences and a random
// run against a queue-based model.  Rev 1.0
// -----------------------------------------------------------------------------
module tb_fft_sample_feeder;

  localparam int DATAW     = 32;
  localparam int DEPTH     = 4;
  localparam int FRAME_LEN = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             fft_wr_en_in = 1'b0;
  logic [DATAW-1:0] ex_data_in = '0;
  logic             abort = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [DATAW-1:0] out_data;
  logic             out_last;
  logic             stall_out;
  logic             frame_done;
  logic             overflow;
`ifdef FFT_FEEDER_STATS_EN
  logic [15:0]      frame_count;
`endif

  fft_sample_feeder #(
    .DATAW     (DATAW),
    .DEPTH     (DEPTH),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fft_wr_en_in (fft_wr_en_in),
    .ex_data_in   (ex_data_in),
    .abort        (abort),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .stall_out    (stall_out),
    .frame_done   (frame_done),
    .overflow     (overflow)
`ifdef FFT_FEEDER_STATS_EN
    ,
    .frame_count  (frame_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [DATAW-1:0] act, input logic [DATAW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    fft_wr_en_in = 1'b0;
    abort        = 1'b0;
    out_ready    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Streams FRAME_LEN consecutive samples with the core always ready.
  task automatic run_frame(input logic [DATAW-1:0] base);
    for (int i = 0; i <= FRAME_LEN; i++) begin
      fft_wr_en_in = (i < FRAME_LEN);
      ex_data_in   = base + DATAW'(i);
      out_ready    = 1'b1;
      tick();
      if (i < FRAME_LEN) begin
        chk("frame_valid", out_valid, 1);
        chk("frame_data", out_data, base + DATAW'(i));
        chk("frame_last", out_last, (i == FRAME_LEN - 1));
      end else begin
        chk("frame_drain_valid", out_valid, 0);
      end
      chk("frame_done", frame_done, (i == FRAME_LEN));
    end
    fft_wr_en_in = 1'b0;
    tick();
    chk("frame_done_one_cycle", frame_done, 0);
  endtask

  typedef struct {
    logic             wr;
    logic [DATAW-1:0] data;
    logic             rdy;
    logic             exp_valid;
    logic [DATAW-1:0] exp_data;
    logic             exp_stall;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[10];

  // Reference model state
  logic [DATAW-1:0] mq[$];
  int               m_idx;
  bit               m_done;
  bit               m_ovf;
  int               m_frames;

  initial begin
    vecs[0] = '{1, 32'hA,    0, 1, 32'hA, 0, 0};
    vecs[1] = '{1, 32'hB,    0, 1, 32'hA, 0, 0};
    vecs[2] = '{1, 32'hC,    0, 1, 32'hA, 1, 0};
    vecs[3] = '{1, 32'hD,    0, 1, 32'hA, 1, 0};
    vecs[4] = '{1, 32'hE,    1, 1, 32'hB, 1, 0};
    vecs[5] = '{1, 32'hDEAD, 0, 1, 32'hB, 1, 1};
    vecs[6] = '{0, 32'h0,    1, 1, 32'hC, 1, 1};
    vecs[7] = '{0, 32'h0,    1, 1, 32'hD, 0, 1};
    vecs[8] = '{0, 32'h0,    1, 1, 32'hE, 0, 1};
    vecs[9] = '{0, 32'h0,    1, 0, 32'h0, 0, 1};

    // Reset state
    rst_n = 1'b0;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ovf", overflow, 0);
    do_reset();

    // Back-pressure, full push+pop, overflow drop and drain
    for (int i = 0; i < 10; i++) begin
      fft_wr_en_in = vecs[i].wr;
      ex_data_in   = vecs[i].data;
      out_ready    = vecs[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_stall", i), stall_out, vecs[i].exp_stall);
      chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].exp_ovf);
      chk($sformatf("vec%0d_last", i), out_last, 0);
    end
    fft_wr_en_in = 1'b0;
    out_ready    = 1'b0;
    tick();
    chk("ovf_sticky", overflow, 1);
    do_reset();
    chk("ovf_cleared_by_reset", overflow, 0);

    // Frame of 0..15
    run_frame(32'h0);

    // Abort mid-frame clears the FIFO and the sample counter
    do_reset();
    for (int i = 0; i < 5; i++) begin
      fft_wr_en_in = 1'b1;
      ex_data_in   = 32'h50 + DATAW'(i);
      out_ready    = 1'b1;
      tick();
    end
    fft_wr_en_in = 1'b0;
    out_ready    = 1'b0;
    abort        = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_stall", stall_out, 0);
    chk("abort_ovf", overflow, 0);
    run_frame(32'h100);

    // Reset asserted mid-frame
    do_reset();
    for (int i = 0; i < 8; i++) begin
      fft_wr_en_in = 1'b1;
      ex_data_in   = 32'h200 + DATAW'(i);
      out_ready    = 1'b1;
      tick();
    end
    chk("pre_rst_data", out_data, 32'h207);
    fft_wr_en_in = 1'b0;
    out_ready    = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_last", out_last, 0);
    chk("midrst_stall", stall_out, 0);
    chk("midrst_done", frame_done, 0);
    chk("midrst_ovf", overflow, 0);
`ifdef FFT_FEEDER_STATS_EN
    chk("midrst_frame_count", frame_count, 0);
`endif
    tick();
    rst_n = 1'b1;
    run_frame(32'h300);
`ifdef FFT_FEEDER_STATS_EN
    chk("frame_count_one", frame_count, 1);
`endif

    // Random traffic against the queue model
    do_reset();
    mq.delete();
    m_idx = 0; m_done = 0; m_ovf = 0; m_frames = 0;
    for (int n = 0; n < 1200; n++) begin
      bit pop, push, last;
      fft_wr_en_in = ($urandom_range(0, 3) != 0);
      ex_data_in   = $urandom;
      out_ready    = (n < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      abort        = ($urandom_range(0, 63) == 0);
      last = (mq.size() != 0) && (m_idx == FRAME_LEN - 1);
      chk("rnd_valid", out_valid, (mq.size() != 0));
      chk("rnd_data", out_data, (mq.size() != 0) ? mq[0] : '0);
      chk("rnd_last", out_last, last);
      chk("rnd_stall", stall_out, (mq.size() >= DEPTH - 1));
      chk("rnd_done", frame_done, m_done);
      chk("rnd_ovf", overflow, m_ovf);
`ifdef FFT_FEEDER_STATS_EN
      chk("rnd_frame_count", frame_count, DATAW'(m_frames % 65536));
`endif
      @(posedge clk);
      if (abort) begin
        mq.delete();
        m_idx  = 0;
        m_done = 0;
      end else begin
        pop  = (mq.size() != 0) && out_ready;
        push = fft_wr_en_in && ((mq.size() < DEPTH) || pop);
        if (fft_wr_en_in && !push) m_ovf = 1;
        m_done = pop && last;
        if (pop) begin
          void'(mq.pop_front());
          m_idx = (m_idx + 1) % FRAME_LEN;
          if (last) m_frames++;
        end
        if (push) mq.push_back(ex_data_in);
      end
      #1;
    end
    abort = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_sample_feeder.md
FFT_SAMPLE_FEEDER -- requirements
Module: fft_sample_feeder

Interface
REQ-001 SHALL have parameter DATAW, default 32, sample/data width.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter FRAME_LEN, default 16, samples per FFT frame (power of two, >=2).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port fft_wr_en_in  input  1  sample write strobe from EX/MEM stage.
REQ-007 SHALL have port ex_data_in  input  DATAW  sample data from EX/MEM stage.
REQ-008 SHALL have port abort  input  1  discard buffered samples and the partial frame.
REQ-009 SHALL have port out_valid  output  1  sample available to FFT core.
REQ-010 SHALL have port out_data  output  DATAW  head-of-FIFO sample.
REQ-011 SHALL have port out_last  output  1  out_data is the final sample of a frame.
REQ-012 SHALL have port out_ready  input  1  FFT core accepts the sample.
REQ-013 SHALL have port stall_out  output  1  back-pressure to pipeline stall input.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse when a last sample is accepted.
REQ-015 SHALL have port overflow  output  1  sticky: write arrived while FIFO full.

Function
REQ-016 SHALL push ex_data_in into the FIFO on a rising clk edge with fft_wr_en_in=1 and FIFO not full.
REQ-017 SHALL drive out_valid=1 whenever FIFO non-empty; minimum latency from push to out_valid is 1 cycle.
REQ-018 SHALL pop the head entry on a clk edge with out_valid=1 and out_ready=1.
REQ-019 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-020 SHALL accept a simultaneous push and pop, occupancy unchanged, including when full.
REQ-021 SHALL drive stall_out=1 combinationally while occupancy >= DEPTH-1, so the one in-flight write always fits.
REQ-022 SHALL, on a push while full without a simultaneous pop, drop the sample and set overflow until reset.
REQ-023 SHALL count samples accepted at the output in a log2(FRAME_LEN)-bit counter, wrapping FRAME_LEN-1 -> 0.
REQ-024 SHALL assert out_last when out_valid=1 and counter = FRAME_LEN-1.
REQ-025 SHALL pulse frame_done for exactly the cycle after a pop with out_last=1.
REQ-026 SHALL implement states IDLE (counter=0, FIFO empty), STREAM (frame in progress or data buffered); IDLE->STREAM on push, STREAM->IDLE on last-sample pop with FIFO then empty.
REQ-027 SHALL, on abort=1 at a clk edge, empty the FIFO, clear the counter, enter IDLE, and ignore any simultaneous push/pop; overflow unaffected.

Reset
REQ-028 SHALL, while rst_n=0, force FIFO empty, counter=0, state IDLE, out_valid=0, out_last=0, out_data=0, stall_out=0, frame_done=0, overflow=0.
REQ-029 SHALL discard any partial frame on reset mid-operation; the first post-reset sample is frame index 0.

Configuration
REQ-030 SHALL, with macro FFT_FEEDER_STATS_EN defined, add output frame_count (16 bits, frames completed, wraps at 65535 -> 0, cleared by reset only, not by abort).
REQ-031 SHALL, without FFT_FEEDER_STATS_EN, omit frame_count and its register entirely.

Structure
REQ-032 SHALL take DATAW, DEPTH, FRAME_LEN defaults and the state enum (IDLE, STREAM) from shared package fft_pkg.
REQ-033 SHALL place the FIFO storage, pointers and occupancy in sub-module fft_feed_fifo (ports: clk, rst_n, clr, push, pop, din, dout, count, full, empty).

Verification
REQ-034 SHALL cover: 16 pushes 0..15 with out_ready=1 -> out_data 0..15 in order, out_last only on 15, frame_done one cycle after.
REQ-035 SHALL cover: out_ready=0, push 0xA,0xB,0xC -> stall_out=1 after third push (DEPTH=4), data held at 0xA.
REQ-036 SHALL cover: full FIFO, out_ready=0, push 0xDEAD -> sample dropped, overflow=1 until reset.
REQ-037 SHALL cover: full FIFO, push and pop same edge -> occupancy stays 4, no overflow.
REQ-038 SHALL cover: 5 samples pushed, abort pulsed -> out_valid=0 next cycle; next 16 pushes form a full frame with out_last on 16th.
REQ-039 SHALL cover: rst_n low mid-frame (sample 7) -> all outputs 0; with FFT_FEEDER_STATS_EN, frame_count=0 and increments to 1 after one full frame.
